// File: rtl/triangle_setup.sv
// triangle_setup
// Captures one 168-bit triangle word per handshake, derives the three edge
// functions (A, B, C) and the signed double-area, normalises winding so the
// interior is positive, clamps the bounding box to the screen and hands the
// result to the rasterizer over valid/ready. Degenerate or fully off-screen
// triangles are discarded and counted.
module triangle_setup #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [167:0] texel_buffer,
    input  logic         texel_ready,
    output logic         texel_read,
    output logic         setup_valid,
    input  logic         setup_ready,
    output logic [16:0]  setup_a0,
    output logic [16:0]  setup_a1,
    output logic [16:0]  setup_a2,
    output logic [16:0]  setup_b0,
    output logic [16:0]  setup_b1,
    output logic [16:0]  setup_b2,
    output logic [33:0]  setup_c0,
    output logic [33:0]  setup_c1,
    output logic [33:0]  setup_c2,
    output logic [34:0]  setup_area,
    output logic [15:0]  setup_xmin,
    output logic [15:0]  setup_xmax,
    output logic [15:0]  setup_ymin,
    output logic [15:0]  setup_ymax,
    output logic [47:0]  setup_z,
    output logic [23:0]  setup_color,
    output logic [15:0]  drop_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EDGE0  = 3'd1,
        S_EDGE1  = 3'd2,
        S_EDGE2  = 3'd3,
        S_AREA   = 3'd4,
        S_ORIENT = 3'd5,
        S_OUTPUT = 3'd6
    } state_t;

    localparam logic signed [15:0] X_LIM = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] Y_LIM = 16'(SCREEN_H - 1);

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Unpack the incoming triangle word into per-vertex fields
    // ------------------------------------------------------------------
    logic signed [15:0] in_x [3];
    logic signed [15:0] in_y [3];
    logic        [15:0] in_z [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
            assign in_x[gi] = texel_buffer[48*gi      +: 16];
            assign in_y[gi] = texel_buffer[48*gi + 16 +: 16];
            assign in_z[gi] = texel_buffer[48*gi + 32 +: 16];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Captured triangle
    // ------------------------------------------------------------------
    logic signed [15:0] vx_q [3];
    logic signed [15:0] vy_q [3];
    logic        [47:0] z_q;
    logic        [23:0] color_q;

    // Latch the triangle on the single cycle upstream offers it in IDLE
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 3; i++) begin
                vx_q[i] <= '0;
                vy_q[i] <= '0;
            end
            z_q     <= '0;
            color_q <= '0;
        end else if (state_q == S_IDLE && texel_ready) begin
            for (int i = 0; i < 3; i++) begin
                vx_q[i] <= in_x[i];
                vy_q[i] <= in_y[i];
            end
            z_q     <= {in_z[2], in_z[1], in_z[0]};
            color_q <= texel_buffer[167:144];
        end
    end

    // ------------------------------------------------------------------
    // Edge evaluation: one edge per cycle through two shared multipliers.
    // Edge k runs from vertex ia to vertex ib.
    // ------------------------------------------------------------------
    logic [1:0] ia, ib, edge_idx;
    logic       edge_en;

    // Pick the vertex pair for the edge computed in the current state
    always_comb begin
        ia       = 2'd0;
        ib       = 2'd1;
        edge_idx = 2'd2;
        edge_en  = 1'b0;
        case (state_q)
            S_EDGE0: begin ia = 2'd1; ib = 2'd2; edge_idx = 2'd0; edge_en = 1'b1; end
            S_EDGE1: begin ia = 2'd2; ib = 2'd0; edge_idx = 2'd1; edge_en = 1'b1; end
            S_EDGE2: begin ia = 2'd0; ib = 2'd1; edge_idx = 2'd2; edge_en = 1'b1; end
            default: ;
        endcase
    end

    logic signed [15:0] xa, ya, xb, yb;
    logic signed [31:0] mul_p, mul_n;
    logic signed [16:0] edge_a, edge_b;
    logic signed [33:0] edge_c;

    assign xa = vx_q[ia];
    assign ya = vy_q[ia];
    assign xb = vx_q[ib];
    assign yb = vy_q[ib];

    assign mul_p = xa * yb;
    assign mul_n = xb * ya;

    // Full-precision differences: 17 bits for A/B, 34 bits for C
    assign edge_a = {ya[15], ya} - {yb[15], yb};
    assign edge_b = {xb[15], xb} - {xa[15], xa};
    assign edge_c = {{2{mul_p[31]}}, mul_p} - {{2{mul_n[31]}}, mul_n};

    logic signed [16:0] ea_q [3];
    logic signed [16:0] eb_q [3];
    logic signed [33:0] ec_q [3];

    // Store the coefficients of the edge evaluated this cycle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 3; i++) begin
                ea_q[i] <= '0;
                eb_q[i] <= '0;
                ec_q[i] <= '0;
            end
        end else if (edge_en) begin
            ea_q[edge_idx] <= edge_a;
            eb_q[edge_idx] <= edge_b;
            ec_q[edge_idx] <= edge_c;
        end
    end

    // ------------------------------------------------------------------
    // Area and clamped bounding box
    // ------------------------------------------------------------------
    logic signed [34:0] area_sum;
    logic signed [15:0] raw_xmin, raw_xmax, raw_ymin, raw_ymax;
    logic signed [15:0] clamp_xmin, clamp_xmax, clamp_ymin, clamp_ymax;

    assign area_sum = {ec_q[0][33], ec_q[0]} + {ec_q[1][33], ec_q[1]} + {ec_q[2][33], ec_q[2]};

    // Raw min/max over the three vertices, then clamp to the visible screen
    always_comb begin
        raw_xmin = vx_q[0];
        raw_xmax = vx_q[0];
        raw_ymin = vy_q[0];
        raw_ymax = vy_q[0];
        for (int i = 1; i < 3; i++) begin
            if (vx_q[i] < raw_xmin) raw_xmin = vx_q[i];
            if (vx_q[i] > raw_xmax) raw_xmax = vx_q[i];
            if (vy_q[i] < raw_ymin) raw_ymin = vy_q[i];
            if (vy_q[i] > raw_ymax) raw_ymax = vy_q[i];
        end
        clamp_xmin = (raw_xmin < 16'sd0) ? 16'sd0 : raw_xmin;
        clamp_xmax = (raw_xmax > X_LIM)  ? X_LIM  : raw_xmax;
        clamp_ymin = (raw_ymin < 16'sd0) ? 16'sd0 : raw_ymin;
        clamp_ymax = (raw_ymax > Y_LIM)  ? Y_LIM  : raw_ymax;
    end

    logic signed [34:0] area_q;
    logic signed [15:0] bxmin_q, bxmax_q, bymin_q, bymax_q;

    // Register area and clamped box in the AREA state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            area_q  <= '0;
            bxmin_q <= '0;
            bxmax_q <= '0;
            bymin_q <= '0;
            bymax_q <= '0;
        end else if (state_q == S_AREA) begin
            area_q  <= area_sum;
            bxmin_q <= clamp_xmin;
            bxmax_q <= clamp_xmax;
            bymin_q <= clamp_ymin;
            bymax_q <= clamp_ymax;
        end
    end

    // ------------------------------------------------------------------
    // Orientation / drop decision
    // ------------------------------------------------------------------
    logic tri_drop;
    logic area_neg;

    assign tri_drop = (area_q == '0) || (bxmin_q > bxmax_q) || (bymin_q > bymax_q);
    assign area_neg = area_q[34];

    logic signed [16:0] oa_q [3];
    logic signed [16:0] ob_q [3];
    logic signed [33:0] oc_q [3];
    logic signed [34:0] oarea_q;
    logic        [15:0] oxmin_q, oxmax_q, oymin_q, oymax_q;
    logic        [47:0] oz_q;
    logic        [23:0] ocolor_q;

    // Load the output registers with winding-normalised results; they then
    // stay frozen through OUTPUT regardless of backpressure
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 3; i++) begin
                oa_q[i] <= '0;
                ob_q[i] <= '0;
                oc_q[i] <= '0;
            end
            oarea_q  <= '0;
            oxmin_q  <= '0;
            oxmax_q  <= '0;
            oymin_q  <= '0;
            oymax_q  <= '0;
            oz_q     <= '0;
            ocolor_q <= '0;
        end else if (state_q == S_ORIENT && !tri_drop) begin
            for (int i = 0; i < 3; i++) begin
                oa_q[i] <= area_neg ? -ea_q[i] : ea_q[i];
                ob_q[i] <= area_neg ? -eb_q[i] : eb_q[i];
                oc_q[i] <= area_neg ? -ec_q[i] : ec_q[i];
            end
            oarea_q  <= area_neg ? -area_q : area_q;
            oxmin_q  <= bxmin_q;
            oxmax_q  <= bxmax_q;
            oymin_q  <= bymin_q;
            oymax_q  <= bymax_q;
            oz_q     <= z_q;
            ocolor_q <= color_q;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: fixed compute sequence, drop or present, then handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (texel_ready) state_d = S_EDGE0;
            S_EDGE0:  state_d = S_EDGE1;
            S_EDGE1:  state_d = S_EDGE2;
            S_EDGE2:  state_d = S_AREA;
            S_AREA:   state_d = S_ORIENT;
            S_ORIENT: state_d = tri_drop ? S_IDLE : S_OUTPUT;
            S_OUTPUT: if (setup_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    logic        texel_read_q;
    logic        setup_valid_q;
    logic [15:0] drop_count_q;

    // Handshake flags registered from the next state so they line up with it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            texel_read_q  <= 1'b0;
            setup_valid_q <= 1'b0;
        end else begin
            texel_read_q  <= (state_d != S_IDLE);
            setup_valid_q <= (state_d == S_OUTPUT);
        end
    end

    // Saturating count of discarded triangles
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            drop_count_q <= '0;
        end else if (state_q == S_ORIENT && tri_drop && drop_count_q != 16'hFFFF) begin
            drop_count_q <= drop_count_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign texel_read  = texel_read_q;
    assign setup_valid = setup_valid_q;
    assign drop_count  = drop_count_q;

    assign setup_a0    = oa_q[0];
    assign setup_a1    = oa_q[1];
    assign setup_a2    = oa_q[2];
    assign setup_b0    = ob_q[0];
    assign setup_b1    = ob_q[1];
    assign setup_b2    = ob_q[2];
    assign setup_c0    = oc_q[0];
    assign setup_c1    = oc_q[1];
    assign setup_c2    = oc_q[2];
    assign setup_area  = oarea_q;
    assign setup_xmin  = oxmin_q;
    assign setup_xmax  = oxmax_q;
    assign setup_ymin  = oymin_q;
    assign setup_ymax  = oymax_q;
    assign setup_z     = oz_q;
    assign setup_color = ocolor_q;

endmodule

// File: doc/triangle_setup.md
# triangle_setup

Downstream consumer of the texel assembler's 168-bit triangle word. It captures one triangle per handshake and computes three edge-function coefficient sets (A, B, C) plus the signed double-area. It normalises winding so the triangle interior is always positive, computes a screen-clamped bounding box, and drops degenerate or fully off-screen triangles. The result is presented to the rasterizer over a valid/ready interface.

## Interface
- SCREEN_W, 640, screen width in pixels; clamp limit for x is SCREEN_W-1
- SCREEN_H, 480, screen height in pixels; clamp limit for y is SCREEN_H-1
- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- texel_buffer  in  168  triangle word; [167:144] color RGB888; v2=[143:96], v1=[95:48], v0=[47:0]; each vertex {z[47:32], y[31:16], x[15:0]}, all signed 16-bit
- texel_ready  in  1  texel_buffer valid; upstream holds it while texel_read=1
- texel_read  out  1  hold/busy to upstream: 1 = cannot accept; 0 = capturing
- setup_valid  out  1  setup result valid
- setup_ready  in  1  rasterizer accepts the result
- setup_a0/a1/a2, setup_b0/b1/b2  out  17 each  signed edge coefficients A_i, B_i
- setup_c0/c1/c2  out  34 each  signed edge constants C_i
- setup_area  out  35  signed double-area after normalisation; always >0 when valid
- setup_xmin, setup_xmax, setup_ymin, setup_ymax  out  16 each  clamped bounding box
- setup_z  out  48  {z2, z1, z0} pass-through
- setup_color  out  24  color pass-through
- drop_count  out  16  count of dropped triangles; saturates at 16'hFFFF

## Operation
- States: IDLE, EDGE0, EDGE1, EDGE2, AREA, ORIENT, OUTPUT.
- texel_read is 0 only in IDLE and is registered from state.
- IDLE:
  - If texel_ready=1, latch texel_buffer and go to EDGE0.
  - Upstream presents texel_ready for one cycle when texel_read=0, so capture is mandatory on that cycle.
- Edge (a→b) definitions: A = ya−yb, B = xb−xa, C = xa·yb − xb·ya. All are sign-extended with full precision and no truncation.
- EDGE0 computes edge 0 (v1→v2), EDGE1 computes edge 1 (v2→v0), EDGE2 computes edge 2 (v0→v1). Each state takes one cycle using two shared 16×16 signed multipliers.
- AREA:
  - area = C0+C1+C2 (35-bit signed).
  - Raw bbox = min/max of x0..x2 and y0..y2.
  - Clamp: xmin = max(0, min), xmax = min(SCREEN_W−1, max); y likewise.
- ORIENT:
  - Drop if area==0, or if clamped xmin>xmax or ymin>ymax. On a drop: drop_count++ (saturating), go to IDLE, no setup_valid.
  - If area<0, negate all A_i, B_i, C_i and area.
  - Then go to OUTPUT.
- OUTPUT: setup_valid=1 and outputs held stable until setup_ready=1. The transfer happens on that edge; go to IDLE.
- Outputs are registered.

## Timing
- Reset values:
  - state IDLE, texel_read=0, setup_valid=0, drop_count=0.
  - All setup_* data outputs are 0.
- Capture on edge E0 (IDLE, texel_ready=1). The FSM passes EDGE0@E0, EDGE1@E1, EDGE2@E2, AREA@E3, ORIENT@E4.
- setup_valid rises at E5, giving latency 5 cycles from capture to valid.
- A drop is visible in drop_count at E5.
- Throughput: minimum 7 cycles per triangle (capture, 5 compute, 1 transfer). IDLE is re-entered after the transfer edge.
- Backpressure:
  - setup_ready may be low indefinitely; outputs are frozen.
  - texel_read stays 1, so upstream holds its triangle.
- setup_ready asserted while setup_valid=0 has no effect.
- texel_ready while not IDLE is ignored; upstream is held by texel_read.
- Async reset mid-operation:
  - Immediately returns to IDLE and clears setup_valid and drop_count.
  - The in-flight triangle is discarded.
- drop_count at 16'hFFFF stays 16'hFFFF.

## Test plan
- Basic triangle: v0=(0,0), v1=(10,0), v2=(0,10), z=0, color 24'hFF0000, setup_ready=1 → setup_valid 5 cycles after capture with:
  - A=(−10,10,0), B=(−10,0,10), C=(100,0,0), area=100.
  - bbox 0..10 × 0..10; color FF0000.
- Winding: v1 and v2 swapped → raw area −100; outputs A=(−10,0,10), B=(−10,10,0), C=(100,0,0), area=100 (interior positive).
- Drops:
  - Collinear (0,0), (5,5), (10,10) → no setup_valid, drop_count=1, texel_read=0 at E5.
  - All x in −50..−10 → clamped xmin 0 > xmax −10 → dropped, drop_count=2.
- Clamp and backpressure:
  - v=(−20,−20), (700,0), (0,500) → bbox 0..639 × 0..479.
  - Hold setup_ready=0 for 20 cycles → outputs stable, texel_read=1, second texel_ready not captured.
  - Then setup_ready=1 → one transfer; next triangle captured.
- Reset: assert n_rst=0 in EDGE2 → setup_valid=0, texel_read=0, drop_count=0 immediately. The next triangle after release is processed normally.
